// File: rtl/mips_run_pkg.sv
// Shared types for the MIPS run controller.
// State encoding and the halt repeat counter width helper.
package mips_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } run_state_e;

  function automatic int rep_width(input int halt_repeat);
    return $clog2(halt_repeat + 1);
  endfunction

endpackage

// File: rtl/mips_halt_detect.sv
// PC self-loop detector for the run controller.
// Flags a halt after HALT_REPEAT consecutive equal-PC compares.
import mips_run_pkg::*;

module mips_halt_detect #(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_REPEAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt_hit
);

  localparam int REP_W = rep_width(HALT_REPEAT);

  logic [PC_WIDTH-1:0] pc_q;
  logic [REP_W-1:0]    rep_q;
  logic                seen_q;
  logic                match;

  // The first RUN edge has no valid previous PC to compare with.
  assign match    = seen_q && (pc == pc_q);
  assign halt_hit = en && match &&
                    (rep_q == REP_W'(HALT_REPEAT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pc_q   <= '0;
      rep_q  <= '0;
      seen_q <= 1'b0;
    end else if (en) begin
      pc_q   <= pc;
      seen_q <= 1'b1;
      rep_q  <= match ? rep_q + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: reset pulse, gated execution, cycle count,
// halt by request or PC self-loop, and timeout.
import mips_run_pkg::*;

module mips_run_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 2,
  parameter int HALT_REPEAT  = 4,
  parameter int MAX_CYCLES   = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  halt_pc
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);

  run_state_e          state_q;
  logic [RC_W-1:0]     rcnt_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PC_WIDTH-1:0] hpc_q;
  logic                launch;
  logic                in_run;
  logic                halt_hit;

  assign in_run = (state_q == S_RUN);
  assign launch = start && (state_q == S_IDLE ||
                            state_q == S_DONE ||
                            state_q == S_TIMEOUT);

  mips_halt_detect #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clk      (clk),
    .reset    (reset),
    .clr      (launch),
    .en       (in_run),
    .pc       (pc),
    .halt_hit (halt_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      cnt_q   <= '0;
      hpc_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state_q <= S_RESET;
            rcnt_q  <= '0;
            cnt_q   <= '0;
            hpc_q   <= '0;
          end
        end
        S_RESET: begin
          if (rcnt_q == RC_W'(RESET_CYCLES - 1))
            state_q <= S_RUN;
          else
            rcnt_q <= rcnt_q + 1'b1;
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          // A halt on the final timeout edge still counts as DONE.
          if (halt_req || halt_hit) begin
            state_q <= S_DONE;
            hpc_q   <= pc;
          end else if (cnt_q == CNT_WIDTH'(MAX_CYCLES - 1)) begin
            state_q <= S_TIMEOUT;
            hpc_q   <= pc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_reset   = !in_run;
  assign cpu_en      = in_run;
  assign busy        = (state_q == S_RESET) || in_run;
  assign done        = (state_q == S_DONE);
  assign timeout     = (state_q == S_TIMEOUT);
  assign cycle_count = cnt_q;
  assign halt_pc     = hpc_q;

endmodule
